// File: rtl/pong_pkg.sv
// Shared pong playfield constants and the AI opponent state encoding.
// Imported by the ball, paddle and cpu_paddle blocks.
package pong_pkg;

  localparam logic [9:0] X_MIN    = 10'd0;
  localparam logic [9:0] X_MAX    = 10'd639;
  localparam logic [9:0] X_CENTER = 10'd320;
  localparam logic [9:0] Y_MIN    = 10'd0;
  localparam logic [9:0] Y_MAX    = 10'd479;
  localparam logic [9:0] Y_CENTER = 10'd240;

  typedef enum logic [1:0] {
    CENTER = 2'd0,
    REACT  = 2'd1,
    TRACK  = 2'd2
  } ai_state_t;

  // Magnitude of an 11-bit signed difference between two 10-bit coordinates.
  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    logic [10:0] r;
    if (v[10]) begin
      r = 11'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_step_clamp.sv
// Rate-limited move of a position toward a target, with deadband and range clamp.
// Purely combinational; shared by the player and CPU paddle logic.
module pong_step_clamp
  import pong_pkg::*;
(
  input  logic [9:0] cur,
  input  logic [9:0] target,
  input  logic [9:0] max_step,
  input  logic [9:0] deadband,
  input  logic [9:0] lo,
  input  logic [9:0] hi,
  output logic [9:0] next_pos
);

  logic signed [10:0] err;
  logic        [10:0] mag;
  logic        [10:0] step_mag;
  logic signed [11:0] sum;

  // Signed step limited to max_step, then clamped in a 12-bit domain so it never wraps.
  always_comb begin
    err = $signed({1'b0, target}) - $signed({1'b0, cur});
    mag = abs11(err);
    if (mag <= {1'b0, deadband}) begin
      step_mag = 11'd0;
    end else if (mag > {1'b0, max_step}) begin
      step_mag = {1'b0, max_step};
    end else begin
      step_mag = mag;
    end
    if (err[10]) begin
      sum = $signed({2'b00, cur}) - $signed({1'b0, step_mag});
    end else begin
      sum = $signed({2'b00, cur}) + $signed({1'b0, step_mag});
    end
    if (sum < $signed({2'b00, lo})) begin
      next_pos = lo;
    end else if (sum > $signed({2'b00, hi})) begin
      next_pos = hi;
    end else begin
      next_pos = sum[9:0];
    end
  end

endmodule

// File: rtl/cpu_paddle.sv
// Computer-controlled right-side paddle: reacts late, moves slowly and drifts
// back to centre when the ball is leaving, so the opponent stays beatable.
module cpu_paddle
  import pong_pkg::*;
#(
  parameter int PADDLE_X     = 600,
  parameter int PADDLE_S     = 24,
  parameter int MAX_STEP     = 3,
  parameter int DEADBAND     = 4,
  parameter int REACT_FRAMES = 8,
  parameter int JUMP_THRESH  = 16
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  output logic [9:0] PaddleX,
  output logic [9:0] PaddleY,
  output logic [9:0] PaddleS,
  output logic [1:0] AiState
);

  localparam logic [9:0]  PADDLE_X_W  = 10'(PADDLE_X);
  localparam logic [9:0]  PADDLE_S_W  = 10'(PADDLE_S);
  localparam logic [9:0]  Y_LO        = Y_MIN + PADDLE_S_W;
  localparam logic [9:0]  Y_HI        = Y_MAX - PADDLE_S_W;
  localparam logic [7:0]  REACT_LAST  = 8'(REACT_FRAMES - 1);
  localparam logic [10:0] JUMP_W      = 11'(JUMP_THRESH);

  ai_state_t   state_q, state_d;
  logic [9:0]  paddle_y_q, paddle_y_d;
  logic [9:0]  prev_x_q, prev_x_d;
  logic [7:0]  cnt_q, cnt_d;

  logic signed [10:0] dx;
  logic               approaching;
  logic               respawn;
  logic [9:0]         target_y;
  logic [9:0]         stepped_y;

  assign dx          = $signed({1'b0, BallX}) - $signed({1'b0, prev_x_q});
  assign approaching = (BallX > prev_x_q);
  assign respawn     = (abs11(dx) > JUMP_W);
  assign target_y    = (state_q == TRACK) ? BallY : Y_CENTER;

  pong_step_clamp u_step (
    .cur      (paddle_y_q),
    .target   (target_y),
    .max_step (10'(MAX_STEP)),
    .deadband (10'(DEADBAND)),
    .lo       (Y_LO),
    .hi       (Y_HI),
    .next_pos (stepped_y)
  );

  // Next-state logic; a respawn jump overrides every other transition.
  always_comb begin
    state_d    = state_q;
    paddle_y_d = paddle_y_q;
    prev_x_d   = prev_x_q;
    cnt_d      = cnt_q;
    if (Enable) begin
      prev_x_d = BallX;
      case (state_q)
        CENTER: begin
          paddle_y_d = stepped_y;
          if (approaching) begin
            state_d = REACT;
            cnt_d   = 8'd0;
          end else begin
            state_d = CENTER;
          end
        end
        REACT: begin
          cnt_d = cnt_q + 8'd1;
          if (!approaching) begin
            state_d = CENTER;
          end else if (cnt_q == REACT_LAST) begin
            state_d = TRACK;
          end else begin
            state_d = REACT;
          end
        end
        TRACK: begin
          paddle_y_d = stepped_y;
          if (!approaching) begin
            state_d = CENTER;
          end else begin
            state_d = TRACK;
          end
        end
        default: begin
          state_d = CENTER;
          cnt_d   = 8'd0;
        end
      endcase
      if (respawn) begin
        state_d = CENTER;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_d;
      end
    end else begin
      state_d = CENTER;
    end
  end

  // Frame registers with asynchronous active-high reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= CENTER;
      paddle_y_q <= Y_CENTER;
      prev_x_q   <= X_CENTER;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      paddle_y_q <= paddle_y_d;
      prev_x_q   <= prev_x_d;
      cnt_q      <= cnt_d;
    end
  end

  assign PaddleX = PADDLE_X_W;
  assign PaddleS = PADDLE_S_W;
  assign PaddleY = paddle_y_q;
  assign AiState = state_q;

endmodule

// File: tb/tb_cpu_paddle.sv
// Directed bench for cpu_paddle: a behavioural reference model pushes expected
// PaddleY/AiState into a queue each frame; values are popped after the edge.
module tb_cpu_paddle;

  logic       frame_clk;
  logic       Reset;
  logic       Enable;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] PaddleX;
  logic [9:0] PaddleY;
  logic [9:0] PaddleS;
  logic [1:0] AiState;

  cpu_paddle dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .BallX     (BallX),
    .BallY     (BallY),
    .PaddleX   (PaddleX),
    .PaddleY   (PaddleY),
    .PaddleS   (PaddleS),
    .AiState   (AiState)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int y;
    int st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_y, m_st, m_cnt, m_prev;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mstep(input int c, input int t);
    int e, a, s, n;
    e = t - c;
    a = (e < 0) ? -e : e;
    if (a <= 4) s = 0;
    else s = (a < 3) ? a : 3;
    if (e < 0) s = -s;
    n = c + s;
    if (n < 24) n = 24;
    if (n > 455) n = 455;
    return n;
  endfunction

  task automatic model_reset();
    m_y = 240; m_st = 0; m_cnt = 0; m_prev = 320;
  endtask

  // One frame: drive at negedge, predict, then compare just after the posedge.
  task automatic frame(input int bx, input int by, input bit en);
    exp_t e;
    int   dx, ns;
    bit   appr, resp;
    @(negedge frame_clk);
    BallX  = bx[9:0];
    BallY  = by[9:0];
    Enable = en;
    if (en) begin
      dx   = bx - m_prev;
      appr = (bx > m_prev);
      resp = (dx > 16) || (dx < -16);
      ns   = m_st;
      if (m_st == 0) begin
        m_y = mstep(m_y, 240);
        if (appr) begin ns = 1; m_cnt = 0; end
      end else if (m_st == 1) begin
        if (!appr) ns = 0;
        else if (m_cnt == 7) ns = 2;
        m_cnt++;
      end else begin
        m_y = mstep(m_y, by);
        if (!appr) ns = 0;
      end
      if (resp) begin ns = 0; m_cnt = 0; end
      m_st   = ns;
      m_prev = bx;
    end else begin
      m_st = 0;
    end
    e.y  = m_y;
    e.st = m_st;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("paddle_y", int'(PaddleY), e.y);
      chk("ai_state", int'(AiState), e.st);
    end
  endtask

  initial begin
    int bx;
    int frozen_y;
    Reset  = 1'b1;
    Enable = 1'b1;
    BallX  = 10'd320;
    BallY  = 10'd240;
    model_reset();
    #12;
    chk("rst_paddle_y", int'(PaddleY), 240);
    chk("rst_state", int'(AiState), 0);
    chk("paddle_x", int'(PaddleX), 600);
    chk("paddle_s", int'(PaddleS), 24);
    @(negedge frame_clk);
    Reset = 1'b0;

    // Stationary ball: stays centred.
    for (int i = 0; i < 20; i++) frame(320, 240, 1'b1);
    chk("static_y", int'(PaddleY), 240);
    chk("static_state", int'(AiState), 0);

    // Approaching ball: 8 frames of reaction, then tracking.
    bx = 320;
    for (int i = 1; i <= 11; i++) begin
      bx += 2;
      frame(bx, 400, 1'b1);
      if (i <= 8) begin
        chk("react_state", int'(AiState), 1);
        chk("react_hold_y", int'(PaddleY), 240);
      end else if (i == 9) begin
        chk("track_entry", int'(AiState), 2);
      end else if (i == 10) begin
        chk("track_y1", int'(PaddleY), 243);
      end else begin
        chk("track_y2", int'(PaddleY), 246);
      end
    end

    // Deadband: error of 2 holds, error of 5 moves by 3.
    bx += 2; frame(bx, 248, 1'b1);
    chk("deadband_hold", int'(PaddleY), 246);
    bx += 2; frame(bx, 251, 1'b1);
    chk("deadband_move", int'(PaddleY), 249);

    // Bottom saturation at Y_MAX - PADDLE_S.
    for (int i = 0; i < 80; i++) begin
      bx += 1;
      frame(bx, 479, 1'b1);
      chk("sat_limit", int'(PaddleY <= 10'd455), 1);
    end
    chk("sat_final", int'(PaddleY), 455);

    // Ball reverses: back to CENTER and drift home.
    bx -= 1; frame(bx, 455, 1'b1);
    chk("reverse_state", int'(AiState), 0);
    for (int i = 0; i < 80; i++) begin
      bx -= 1;
      frame(bx, 100, 1'b1);
    end
    chk("home_y", int'(PaddleY), 242);

    // Stationary ball while reacting drops back to CENTER.
    bx += 2; frame(bx, 300, 1'b1);
    chk("react_again", int'(AiState), 1);
    frame(bx, 300, 1'b1);
    chk("stationary_center", int'(AiState), 0);

    // Forward jump is a respawn, not an approach.
    frame(540, 300, 1'b1);
    chk("respawn_priority", int'(AiState), 0);
    bx = 540;
    for (int i = 0; i < 10; i++) begin
      bx += 2;
      frame(bx, 300, 1'b1);
    end
    chk("track_again", int'(AiState), 2);
    frame(320, 300, 1'b1);
    chk("respawn_jump", int'(AiState), 0);

    // Disable while tracking freezes the paddle and forces CENTER.
    bx = 320;
    for (int i = 0; i < 10; i++) begin
      bx += 2;
      frame(bx, 450, 1'b1);
    end
    chk("pre_disable_state", int'(AiState), 2);
    frozen_y = m_y;
    for (int i = 0; i < 5; i++) begin
      bx += 2;
      frame(bx, 50, 1'b0);
      chk("frozen_y", int'(PaddleY), frozen_y);
      chk("disabled_state", int'(AiState), 0);
    end
    bx += 2; frame(bx, 50, 1'b1);
    chk("reenable_stale_prev", int'(AiState), 1);

    // Asynchronous reset in the middle of TRACK.
    for (int i = 0; i < 9; i++) begin
      bx += 2;
      frame(bx, 50, 1'b1);
    end
    chk("pre_reset_state", int'(AiState), 2);
    @(negedge frame_clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_y", int'(PaddleY), 240);
    chk("async_rst_state", int'(AiState), 0);
    model_reset();
    @(negedge frame_clk);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) frame(320, 240, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
